// File: rtl/seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low gfedcba patterns for hex values 0-F
   localparam logic [6:0] SEG_DECODE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {StGuard, StDrive} scan_state_e;

   typedef struct packed {
      logic [3:0] val;
      logic       dp;
      logic       blank;
   } digit_t;

   // Digits 3..1 that read as leading zeros; digit 0 always shows
   function automatic logic [3:0] lz_mask(input digit_t [3:0] d);
      logic above;
      logic zero;
      lz_mask = '0;
      above   = 1'b1;
      for (int k = 3; k >= 1; k--) begin
         zero       = (d[k].val == 4'h0) && !d[k].dp;
         lz_mask[k] = zero && above;
         above      = above && (zero || d[k].blank);
      end
   endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Shadow-bank write port of the seven-segment scan controller.
interface seg_scan_controller_if;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [3:0] wr_val;
   logic       wr_dp;
   logic       wr_blank;

   modport master (output wr_en, wr_idx, wr_val, wr_dp, wr_blank);
   modport slave  (input  wr_en, wr_idx, wr_val, wr_dp, wr_blank);
endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low gfedcba.
module seg_hex_decoder
   import seg_pkg::*;
(
   input  logic [3:0] val_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   assign seg_o = blank_i ? SEG_BLANK : SEG_DECODE[val_i];

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed seven-segment driver with guard intervals and frame-synchronous commit.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned GUARD_CYCLES = 1000
) (
   input  logic                        basys_clock,
   input  logic                        reset,
   seg_scan_controller_if.slave        wr,
   output logic [3:0]                  an,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic                        frame_tick
);

   localparam int unsigned MaxCyc = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
   localparam logic [TimerW-1:0] GuardLoad = TimerW'(GUARD_CYCLES - 1);
   localparam logic [TimerW-1:0] DriveLoad = TimerW'(REFRESH_DIV - 1);

   scan_state_e       state_q, state_d;
   logic [1:0]        dig_q, dig_d;
   logic [TimerW-1:0] timer_q, timer_d;
   digit_t [3:0]      shadow_q, shadow_d, active_q, active_d;
   logic              pending_q, pending_d;
   logic              frame_end;

   logic [3:0]        an_d;
   logic [6:0]        seg_d, dec_seg;
   logic              dp_d, tick_d;
   digit_t            sel;
   logic [3:0]        lz;
   logic              blank_eff;

   always_comb begin
      state_d   = state_q;
      dig_d     = dig_q;
      timer_d   = timer_q;
      frame_end = 1'b0;
      if (timer_q != '0) begin
         timer_d = timer_q - 1'b1;
      end else begin
         unique case (state_q)
            StGuard: begin
               state_d = StDrive;
               timer_d = DriveLoad;
            end
            StDrive: begin
               state_d   = StGuard;
               timer_d   = GuardLoad;
               dig_d     = dig_q + 2'd1;
               frame_end = (dig_q == 2'd3);
            end
            default: ;
         endcase
      end
   end

   // Commit reads the pre-write shadow; a coincident write keeps pending set
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (frame_end) begin
         pending_d = 1'b0;
         if (pending_q) active_d = shadow_q;
      end
      if (wr.wr_en) begin
         shadow_d[wr.wr_idx] = {wr.wr_val, wr.wr_dp, wr.wr_blank};
         pending_d           = 1'b1;
      end
   end

`ifdef SEG_SCAN_LZ_BLANK_EN
   assign lz = lz_mask(active_q);
`else
   assign lz = '0;
`endif

   // Outputs are registered from next state so they line up with state_q
   assign sel       = active_q[dig_d];
   assign blank_eff = sel.blank | lz[dig_d];

   seg_hex_decoder u_dec (
      .val_i   (sel.val),
      .blank_i (blank_eff),
      .seg_o   (dec_seg)
   );

   always_comb begin
      an_d   = 4'hF;
      seg_d  = SEG_BLANK;
      dp_d   = 1'b1;
      tick_d = (state_d == StDrive) && (dig_d == 2'd3) && (timer_d == '0);
      if (state_d == StDrive) begin
         an_d        = 4'hF;
         an_d[dig_d] = 1'b0;
         seg_d       = dec_seg;
         dp_d        = ~(sel.dp & ~blank_eff);
      end
   end

   always_ff @(posedge basys_clock or posedge reset) begin
      if (reset) begin
         state_q    <= StGuard;
         dig_q      <= 2'd0;
         timer_q    <= GuardLoad;
         shadow_q   <= '0;
         active_q   <= '0;
         pending_q  <= 1'b0;
         an         <= 4'hF;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         dig_q      <= dig_d;
         timer_q    <= timer_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         pending_q  <= pending_d;
         an         <= an_d;
         seg        <= seg_d;
         dp         <= dp_d;
         frame_tick <= tick_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with a 24-cycle frame (REFRESH_DIV=4, GUARD_CYCLES=2).
module tb_seg_scan_controller;

   localparam int unsigned Rd    = 4;
   localparam int unsigned Gc    = 2;
   localparam int unsigned Slot  = Rd + Gc;
   localparam int unsigned Frame = 4 * Slot;
`ifdef SEG_SCAN_LZ_BLANK_EN
   localparam bit Lz = 1'b1;
`else
   localparam bit Lz = 1'b0;
`endif
   localparam logic [6:0] Zu = Lz ? 7'h7F : 7'h40;  // upper digit holding 0

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   seg_scan_controller_if wr_bus ();

   seg_scan_controller #(
      .REFRESH_DIV  (Rd),
      .GUARD_CYCLES (Gc)
   ) dut (
      .basys_clock (clk),
      .reset       (rst),
      .wr          (wr_bus),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_tick  (frame_tick)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at the negedge of cycle 0 of a frame; returns at cycle 0 of the next
   task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
      logic [3:0][6:0] sv;
      logic [3:0]      ea;
      sv = {s3, s2, s1, s0};
      for (int c = 0; c < Frame; c++) begin
         int d;
         bit drv;
         d   = c / Slot;
         drv = (c % Slot) >= Gc;
         ea  = 4'hF;
         if (drv) ea[d] = 1'b0;
         check($sformatf("%s an c%0d", tag, c), {4'b0, an}, {4'b0, ea});
         check($sformatf("%s seg c%0d", tag, c), {1'b0, seg}, {1'b0, drv ? sv[d] : 7'h7F});
         check($sformatf("%s dp c%0d", tag, c), {7'b0, dp}, {7'b0, drv ? dpn[d] : 1'b1});
         check($sformatf("%s tick c%0d", tag, c), {7'b0, frame_tick}, {7'b0, c == Frame - 1});
         @(negedge clk);
      end
   endtask

   task automatic do_write(input logic [1:0] idx, input logic [3:0] val, input logic wdp,
                           input logic wblank);
      wr_bus.wr_en    = 1'b1;
      wr_bus.wr_idx   = idx;
      wr_bus.wr_val   = val;
      wr_bus.wr_dp    = wdp;
      wr_bus.wr_blank = wblank;
      @(negedge clk);
      wr_bus.wr_en    = 1'b0;
   endtask

   initial begin
      wr_bus.wr_en    = 1'b0;
      wr_bus.wr_idx   = 2'd0;
      wr_bus.wr_val   = 4'd0;
      wr_bus.wr_dp    = 1'b0;
      wr_bus.wr_blank = 1'b0;
      repeat (3) @(negedge clk);
      check("rst an", {4'b0, an}, 8'h0F);
      check("rst seg", {1'b0, seg}, 8'h7F);
      check("rst dp", {7'b0, dp}, 8'h01);
      check("rst tick", {7'b0, frame_tick}, 8'h00);
      rst = 1'b0;

      run_frame("t1", 7'h40, Zu, Zu, Zu, 4'hF);

      fork
         run_frame("t2a", 7'h40, Zu, Zu, Zu, 4'hF);
         begin
            repeat (3) @(negedge clk);
            do_write(2'd3, 4'h1, 1'b0, 1'b0);
            do_write(2'd2, 4'h2, 1'b0, 1'b0);
            do_write(2'd1, 4'h3, 1'b0, 1'b0);
            do_write(2'd0, 4'h4, 1'b0, 1'b0);
         end
      join
      run_frame("t2b", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF);

      fork
         run_frame("t3a", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
         begin
            repeat (Frame - 1) @(negedge clk);
            do_write(2'd1, 4'hA, 1'b0, 1'b0);
         end
      join
      run_frame("t3b", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
      run_frame("t3c", 7'h19, 7'h08, 7'h24, 7'h79, 4'hF);

      fork
         run_frame("t4a", 7'h19, 7'h08, 7'h24, 7'h79, 4'hF);
         begin
            repeat (4) @(negedge clk);
            do_write(2'd2, 4'h0, 1'b0, 1'b1);
            do_write(2'd0, 4'h8, 1'b1, 1'b0);
         end
      join
      run_frame("t4b", 7'h00, 7'h08, 7'h7F, 7'h79, 4'b1110);

      repeat (2) @(negedge clk);
      do_write(2'd3, 4'h7, 1'b0, 1'b0);
      repeat (12) @(negedge clk);
      check("t5 pre an", {4'b0, an}, 8'h0B);
      rst = 1'b1;
      #1;
      check("t5 async an", {4'b0, an}, 8'h0F);
      check("t5 async seg", {1'b0, seg}, 8'h7F);
      check("t5 async dp", {7'b0, dp}, 8'h01);
      check("t5 async tick", {7'b0, frame_tick}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      run_frame("t5a", 7'h40, Zu, Zu, Zu, 4'hF);
      run_frame("t5b", 7'h40, Zu, Zu, Zu, 4'hF);

      fork
         run_frame("t6a", 7'h40, Zu, Zu, Zu, 4'hF);
         begin
            repeat (3) @(negedge clk);
            do_write(2'd3, 4'h0, 1'b0, 1'b0);
            do_write(2'd2, 4'h0, 1'b0, 1'b0);
            do_write(2'd1, 4'h5, 1'b0, 1'b0);
            do_write(2'd0, 4'h0, 1'b0, 1'b0);
         end
      join
      run_frame("t6b", 7'h40, 7'h12, Zu, Zu, 4'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
